// File: rtl/ghost_navigator.sv
// Single-ghost movement engine: tile position/heading, scatter/chase/fright mode timer, next-direction choice.
// Optional macro GHOST_TUNNEL_EN: left/right moves off the maze edge wrap to the opposite column.
module ghost_navigator #(
    parameter int X_W           = 5,
    parameter int Y_W           = 5,
    parameter int MAX_X         = 27,
    parameter int HOME_X        = 13,
    parameter int HOME_Y        = 11,
    parameter int SCAT_X        = 25,
    parameter int SCAT_Y        = 0,
    parameter int SCATTER_TICKS = 420,
    parameter int CHASE_TICKS   = 1200,
    parameter int FRIGHT_TICKS  = 360,
    parameter int CNT_W         = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           tick,
    input  logic           fright_req,
    input  logic           step_req,
    input  logic [X_W-1:0] target_x,
    input  logic [Y_W-1:0] target_y,
    input  logic [3:0]     can_move,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     dir,
    output logic [1:0]     mode,
    output logic           step_valid
);
    localparam int MW  = (X_W > Y_W) ? X_W : Y_W;
    localparam int D_W = 2 * MW + 3;
    localparam logic [X_W-1:0] MAX_XV  = X_W'(MAX_X);
    localparam logic [X_W-1:0] SCAT_XV = X_W'(SCAT_X);
    localparam logic [Y_W-1:0] SCAT_YV = Y_W'(SCAT_Y);
    localparam logic [CNT_W-1:0] SCAT_LAST   = CNT_W'(SCATTER_TICKS - 1);
    localparam logic [CNT_W-1:0] CHASE_LAST  = CNT_W'(CHASE_TICKS - 1);
    localparam logic [CNT_W-1:0] FRIGHT_LAST = CNT_W'(FRIGHT_TICKS - 1);
    // Tie-break priority U > L > D > R, lowest slot first
    localparam logic [7:0] ORDER = {2'd1, 2'd2, 2'd3, 2'd0};

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_SCAT = 2'd1, M_CHASE = 2'd2, M_FRIGHT = 2'd3} mode_t;

    mode_t            mode_q, saved_mode, mode_p0;
    logic [CNT_W-1:0] timer, fcnt;
    logic             rev_pend;
    logic [7:0]       lfsr;
    logic             vld_p0, vld_p1;

    logic [X_W-1:0]   nx [4];
    logic [Y_W-1:0]   ny [4];
    logic [D_W-1:0]   dd [4];
    logic [3:0]       legal, cand;
    logic [1:0]       rev, d, best_d, fr_d, next_dir;
    logic [D_W-1:0]   best_dist;
    logic             found, fr_found, take_rev, move;
    logic [X_W-1:0]   tx;
    logic [Y_W-1:0]   ty;

    function automatic logic [D_W-1:0] dist_sq(input logic [X_W-1:0] ax, input logic [Y_W-1:0] ay,
                                               input logic [X_W-1:0] bx, input logic [Y_W-1:0] by);
        logic signed [X_W:0]   dx;
        logic signed [Y_W:0]   dy;
        logic signed [D_W-1:0] ex, ey;
        dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy = $signed({1'b0, ay}) - $signed({1'b0, by});
        ex = {{(D_W-X_W-1){dx[X_W]}}, dx};
        ey = {{(D_W-Y_W-1){dy[Y_W]}}, dy};
        return $unsigned(ex * ex + ey * ey);
    endfunction

    assign mode       = mode_q;
    assign step_valid = vld_p1;

    always_comb begin
        legal = can_move;
        nx[0] = pos_x;              ny[0] = pos_y - Y_W'(1);
        nx[1] = pos_x + X_W'(1);    ny[1] = pos_y;
        nx[2] = pos_x;              ny[2] = pos_y + Y_W'(1);
        nx[3] = pos_x - X_W'(1);    ny[3] = pos_y;
`ifdef GHOST_TUNNEL_EN
        if (pos_x == '0)    nx[3] = MAX_XV;
        if (pos_x == MAX_XV) nx[1] = '0;
`else
        if (pos_x == '0)    legal[3] = 1'b0;
        if (pos_x == MAX_XV) legal[1] = 1'b0;
`endif
        rev  = dir ^ 2'd2;
        cand = legal & ~(4'd1 << rev);
        if (cand == 4'd0) cand = legal;
        take_rev = rev_pend && legal[rev];
        tx = (mode_p0 == M_SCAT) ? SCAT_XV : target_x;
        ty = (mode_p0 == M_SCAT) ? SCAT_YV : target_y;
        for (int k = 0; k < 4; k++) dd[k] = dist_sq(nx[k], ny[k], tx, ty);

        d         = 2'd0;
        best_d    = 2'd0;
        best_dist = '1;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = ORDER[2*k +: 2];
            if (cand[d] && (!found || dd[d] < best_dist)) begin
                best_d    = d;
                best_dist = dd[d];
                found     = 1'b1;
            end
        end
        // Frightened: clockwise scan from a pseudo-random start
        fr_d     = lfsr[1:0];
        fr_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = lfsr[1:0] + 2'(k);
            if (cand[d] && !fr_found) begin
                fr_d     = d;
                fr_found = 1'b1;
            end
        end
        move     = take_rev || (cand != 4'd0);
        next_dir = take_rev ? rev : ((mode_p0 == M_FRIGHT) ? fr_d : best_d);
    end

    // p0: step request captured with the mode seen at acceptance
    always_ff @(posedge clk) begin
        if (step_req && !vld_p0 && mode_q != M_IDLE) mode_p0 <= mode_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x      <= X_W'(HOME_X);
            pos_y      <= Y_W'(HOME_Y);
            dir        <= 2'd3;
            mode_q     <= M_IDLE;
            saved_mode <= M_SCAT;
            timer      <= '0;
            fcnt       <= '0;
            rev_pend   <= 1'b0;
            lfsr       <= 8'hA5;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (step_req && !vld_p0 && mode_q != M_IDLE) begin
                vld_p0 <= 1'b1;
                lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            // p1: move committed, step_valid follows
            vld_p1 <= vld_p0;
            if (vld_p0 && move) begin
                pos_x <= nx[next_dir];
                pos_y <= ny[next_dir];
                dir   <= next_dir;
            end
            if (vld_p0 && take_rev) rev_pend <= 1'b0;

            // Mode events take precedence over the reverse clear above
            case (mode_q)
                M_IDLE: begin
                    if (start) begin
                        mode_q <= M_SCAT;
                        timer  <= '0;
                    end
                end
                M_SCAT, M_CHASE: begin
                    if (fright_req) begin
                        saved_mode <= mode_q;
                        mode_q     <= M_FRIGHT;
                        fcnt       <= '0;
                        rev_pend   <= 1'b1;
                    end else if (tick) begin
                        if (timer == ((mode_q == M_SCAT) ? SCAT_LAST : CHASE_LAST)) begin
                            mode_q   <= (mode_q == M_SCAT) ? M_CHASE : M_SCAT;
                            timer    <= '0;
                            rev_pend <= 1'b1;
                        end else begin
                            timer <= timer + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (fright_req) begin
                        fcnt <= '0;
                    end else if (tick) begin
                        if (fcnt == FRIGHT_LAST) mode_q <= saved_mode;
                        else                     fcnt   <= fcnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule
